// File: rtl/gpio_scan_pkg.sv
// gpio_scan_pkg: shared pin-index type and lowest-set-bit helper for the GPIO input scanner
package gpio_scan_pkg;
    localparam int PIN_IDX_W = 5;
    typedef logic [PIN_IDX_W-1:0] pin_idx_t;

    function automatic pin_idx_t lowest_set(input logic [31:0] mask);
        pin_idx_t r;
        r = '0;
        for (int i = 31; i >= 0; i--)
            if (mask[i]) r = pin_idx_t'(i);
        return r;
    endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one pin -- 2-flop synchronizer, tick-sampled history and debounced level
module gpio_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic level
);
    logic [1:0]             sync;
    logic [DEB_SAMPLES-1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (tick) hist <= {hist[DEB_SAMPLES-2:0], sync[1]};
            level <= (&hist) ? 1'b1 : (~|hist) ? 1'b0 : level;
        end
    end
endmodule

// File: rtl/gpio_input_scan.sv
// gpio_input_scan: debounced GPIO rising-edge scanner reporting pin indices over valid/ready
// Optional GPIO_SEQ_CHECK_EN adds a sticky check that accepted indices ascend by one.
module gpio_input_scan
    import gpio_scan_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int DEB_DIV     = 12000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output pin_idx_t            evt_pin,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic                seq_err
);
    localparam int CW = DEB_DIV > 1 ? $clog2(DEB_DIV) : 1;

    logic [CW-1:0]       cnt;
    logic                tick, free, ovf;
    logic [NUM_PINS-1:0] level_d, rise, pending, take, pending_nxt;
    pin_idx_t            sel;

    assign tick = cnt == CW'(DEB_DIV - 1);

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_deb
        gpio_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (gpio_in[i]),
            .tick  (tick),
            .level (level[i])
        );
    end

    // A rise landing on the bit being taken this cycle re-arms it without counting as overrun.
    always_comb begin
        free        = !evt_valid || evt_ready;
        rise        = level & ~level_d;
        sel         = lowest_set(32'(pending));
        take        = (free && |pending) ? NUM_PINS'(1) << sel : '0;
        ovf         = |(rise & pending & ~take);
        pending_nxt = (pending & ~take) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            level_d   <= '0;
            pending   <= '0;
            overrun   <= 1'b0;
            evt_valid <= 1'b0;
            evt_pin   <= '0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            level_d <= level;
            pending <= pending_nxt;
            overrun <= ovf | (overrun & ~overrun_clr);
            if (free) begin
                evt_valid <= |pending;
                if (|pending) evt_pin <= sel;
            end
        end
    end

`ifdef GPIO_SEQ_CHECK_EN
    pin_idx_t exp_idx;

    // Expected index resyncs after every accept so one skipped pin flags once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else if (evt_valid && evt_ready) begin
            if (evt_pin != exp_idx) seq_err <= 1'b1;
            exp_idx <= (evt_pin == pin_idx_t'(NUM_PINS - 1)) ? '0 : evt_pin + 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif
endmodule
